bg0_text_render: RTL and testbench

Text-mode pixel generator for background layer 0, directly downstream of the `bg0_map` glyph BRAM (16K×1, 256 glyphs × 8 rows × 8 columns, synchronous 1-cycle read). It takes raster position and sync from video timing and reads character/attribute words from the text buffer RAM. It then addresses the glyph BRAM, using the returned font bit to select a foreground or background 4-bit palette index. It also overlays a blinking underline cursor, and delays sync/DE to match pipeline latency.

---
 rtl/bg0_text_render.sv | 179 +++++++++++++++++
 tb/tb_bg0_text_render.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bg0_text_render.sv
`default_nettype none
// ============================================================================
// Module   : bg0_text_render
// Purpose  : Text-mode pixel generator for background layer 0. Turns the
//            raster position from video timing into a text-buffer read, then
//            a glyph BRAM read, and selects a fg/bg palette index from the
//            font bit. Overlays a blinking underline cursor and delays
//            DE/HS/VS so they stay aligned with the pixel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                  pixel clock, asynchronous active-low reset
//   x_in, y_in                  active-area pixel column / line
//   de_in, hs_in, vs_in         input data enable and syncs (active-high)
//   text_addr  -> text RAM      cell address (RAM registers it)
//   text_data  <- text RAM      {bg[15:12], fg[11:8], char[7:0]}, 1 clk later
//   font_addr  -> bg0_map addrb {char, row[2:0], col[2:0]}
//   font_bit   <- bg0_map doutb glyph pixel, 1 clk after font_addr
//   cursor_en, cursor_col/row   underline cursor control
//   pix_out                     4-bit palette index
//   de_out, hs_out, vs_out      inputs delayed to match pix_out
// ============================================================================
module bg0_text_render #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int TA_W = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [9:0]      x_in,
  input  logic [9:0]      y_in,
  input  logic            de_in,
  input  logic            hs_in,
  input  logic            vs_in,
  output logic [TA_W-1:0] text_addr,
  input  logic [15:0]     text_data,
  output logic [13:0]     font_addr,
  input  logic            font_bit,
  input  logic            cursor_en,
  input  logic [6:0]      cursor_col,
  input  logic [5:0]      cursor_row,
  output logic [3:0]      pix_out,
  output logic            de_out,
  output logic            hs_out,
  output logic            vs_out
);

  // Elaboration-time guard: the whole text buffer must be addressable.
  if (COLS * ROWS > (1 << TA_W)) begin : g_size_chk
    $error("bg0_text_render: COLS*ROWS exceeds 2**TA_W");
  end

  // Stage 1 registers
  logic [9:0]      r_x_s1;
  logic [9:0]      r_y_s1;
  logic            r_de_s1;
  logic            r_hs_s1;
  logic            r_vs_s1;

  // Running start address of the current text row
  logic [TA_W-1:0] r_line_base;
  logic [4:0]      r_frame_cnt;

  // Stage 2 registers
  logic [3:0]      r_fg_s2;
  logic [3:0]      r_bg_s2;
  logic            r_cur_s2;
  logic            r_de_s2;
  logic            r_hs_s2;
  logic            r_vs_s2;

  // Stage 3 (output) registers
  logic [3:0]      r_pix;
  logic            r_de_o;
  logic            r_hs_o;
  logic            r_vs_o;

  logic            w_blink;
  logic            w_cur_hit;
  logic            w_de_fall;
  logic            w_vs_rise;
  logic            w_pixel;

  // Both RAMs register their address themselves, so the addresses are
  // presented combinationally; the RAM output register forms the stage.
  assign text_addr = r_line_base + TA_W'(x_in[9:3]);
  assign font_addr = {text_data[7:0], r_y_s1[2:0], r_x_s1[2:0]};

  assign w_blink   = r_frame_cnt[4];
  assign w_de_fall = r_de_s1 & ~de_in;
  assign w_vs_rise = ~r_vs_s1 & vs_in;

  // Underline occupies the bottom two glyph lines of the cursor cell.
  assign w_cur_hit = cursor_en & w_blink
                   & (r_x_s1[9:3] == cursor_col)
                   & (r_y_s1[9:3] == {1'b0, cursor_row})
                   & (r_y_s1[2:0] >= 3'd6);

  assign w_pixel   = font_bit ^ r_cur_s2;

  // Stage 1: capture raster position and sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_s1  <= '0;
      r_y_s1  <= '0;
      r_de_s1 <= 1'b0;
      r_hs_s1 <= 1'b0;
      r_vs_s1 <= 1'b0;
    end else begin
      r_x_s1  <= x_in;
      r_y_s1  <= y_in;
      r_de_s1 <= de_in;
      r_hs_s1 <= hs_in;
      r_vs_s1 <= vs_in;
    end
  end

  // Row base: advance one text row after the last glyph line of a row;
  // vsync clears it and wins over a coincident advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_base <= '0;
    end else if (vs_in) begin
      r_line_base <= '0;
    end else if (w_de_fall && (r_y_s1[2:0] == 3'd7)) begin
      r_line_base <= r_line_base + TA_W'(COLS);
    end
  end

  // Frame counter for the cursor blink; wraps naturally at 5 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_vs_rise) begin
      r_frame_cnt <= r_frame_cnt + 5'd1;
    end
  end

  // Stage 2: attribute and cursor flag, aligned with font_bit next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fg_s2  <= '0;
      r_bg_s2  <= '0;
      r_cur_s2 <= 1'b0;
      r_de_s2  <= 1'b0;
      r_hs_s2  <= 1'b0;
      r_vs_s2  <= 1'b0;
    end else begin
      r_fg_s2  <= text_data[11:8];
      r_bg_s2  <= text_data[15:12];
      r_cur_s2 <= w_cur_hit;
      r_de_s2  <= r_de_s1;
      r_hs_s2  <= r_hs_s1;
      r_vs_s2  <= r_vs_s1;
    end
  end

  // Stage 3: colour select; blanking forces index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix  <= '0;
      r_de_o <= 1'b0;
      r_hs_o <= 1'b0;
      r_vs_o <= 1'b0;
    end else begin
      r_pix  <= r_de_s2 ? (w_pixel ? r_fg_s2 : r_bg_s2) : 4'd0;
      r_de_o <= r_de_s2;
      r_hs_o <= r_hs_s2;
      r_vs_o <= r_vs_s2;
    end
  end

  assign pix_out = r_pix;
  assign de_out  = r_de_o;
  assign hs_out  = r_hs_o;
  assign vs_out  = r_vs_o;

endmodule
`default_nettype wire

// File: tb/tb_bg0_text_render.sv
`default_nettype none
// ============================================================================
// Module   : tb_bg0_text_render
// Purpose  : Self-checking bench for bg0_text_render. Models both RAMs,
//            drives short rasters and predicts every output from the cell /
//            glyph / cursor rules directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bg0_text_render;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int TA_W = 13;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [9:0]      x_in, y_in;
  logic            de_in, hs_in, vs_in;
  logic [TA_W-1:0] text_addr;
  logic [15:0]     text_data;
  logic [13:0]     font_addr;
  logic            font_bit;
  logic            cursor_en;
  logic [6:0]      cursor_col;
  logic [5:0]      cursor_row;
  logic [3:0]      pix_out;
  logic            de_out, hs_out, vs_out;

  always #5 clk = ~clk;

  bg0_text_render #(.COLS(COLS), .ROWS(ROWS), .TA_W(TA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_in(x_in), .y_in(y_in), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_bit(font_bit),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .pix_out(pix_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  // Sync-read RAM models (1-clock latency)
  logic [15:0] tram [0:8191];
  logic        fram [0:16383];
  always @(posedge clk) begin
    text_data <= tram[text_addr];
    font_bit  <= fram[font_addr];
  end

  typedef struct {
    logic [3:0] pix;
    logic       de, hs, vs;
    int         gl;
  } exp_t;

  exp_t q[$];
  int   n_tot = 0;
  int   n_pass = 0;
  int   frames;
  bit   prev_vs;
  bit   first_frame;
  logic [3:0] GOLD [0:7] = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'h1, 4'h1, 4'h1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    exp_t z;
    z.pix = 4'd0; z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0; z.gl = -1;
    q.delete();
    repeat (2) q.push_back(z);
    frames  = 0;
    prev_vs = 1'b0;
  endtask

  // One pixel clock: drive, predict, then check the pixel that emerges now.
  task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
    exp_t e, f;
    int a, idx;
    logic [15:0] w;
    logic b, cur;
    x_in = x[9:0]; y_in = y[9:0]; de_in = de; hs_in = hs; vs_in = vs;
    if (vs && !prev_vs) frames++;
    prev_vs = vs;
    a = (y / 8) * COLS + (x / 8);
    w = tram[a];
    idx = int'(w[7:0]) * 64 + (y % 8) * 8 + (x % 8);
    b = fram[idx];
    cur = cursor_en && ((frames % 32) >= 16) && ((x / 8) == int'(cursor_col))
          && ((y / 8) == int'(cursor_row)) && ((y % 8) >= 6);
    e.pix = de ? ((b ^ cur) ? w[11:8] : w[15:12]) : 4'd0;
    e.de = de; e.hs = hs; e.vs = vs;
    e.gl = (first_frame && de && y == 0 && x < 8) ? x : -1;
    q.push_back(e);
    #1;
    if (de) chk("text_addr", text_addr, a);
    if (de && x == 0 && y == 7)   chk("addr_line7", text_addr, 0);
    if (de && x == 0 && y == 8)   chk("addr_line8", text_addr, 80);
    if (de && x == 0 && y == 479) chk("addr_line479", text_addr, 4720);
    @(posedge clk);
    @(negedge clk);
    f = q.pop_front();
    chk("pix_out", pix_out, f.pix);
    chk("de_out", de_out, f.de);
    chk("hs_out", hs_out, f.hs);
    chk("vs_out", vs_out, f.vs);
    if (f.gl >= 0) chk("glyph_pix", pix_out, GOLD[f.gl]);
    if (de) chk("font_addr", font_addr, idx);
    if (e.gl >= 0) chk("glyph_font_addr", font_addr, 14'h1040 + x);
  endtask

  task automatic frame(input int w, input int h, input bit collide);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) step(x, y, 1'b1, 1'b0, 1'b0);
      if (collide && y == 7) begin
        // vsync arrives on the very clock de falls after glyph line 7
        step(0, 0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        return;
      end
      for (int i = 0; i < 4; i++) step(0, 0, 1'b0, (i == 1 || i == 2), 1'b0);
    end
    step(0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] row18;
    row18 = 8'h18;
    for (int i = 0; i < 8192; i++) tram[i] = 16'($urandom);
    for (int i = 0; i < 16384; i++) fram[i] = 1'($urandom);
    tram[0] = 16'h1F41;
    for (int c = 0; c < 8; c++) fram[8'h41 * 64 + c] = row18[7 - c];
    tram[2 * COLS + 5] = 16'h0720;
    for (int i = 0; i < 64; i++) fram[8'h20 * 64 + i] = 1'b0;

    rst_n = 1'b0;
    x_in = '0; y_in = '0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 6'd2;
    first_frame = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_de_out", de_out, 0);
    chk("rst_hs_out", hs_out, 0);
    chk("rst_vs_out", vs_out, 0);
    chk("rst_text_addr", text_addr, 0);
    rst_n = 1'b1;
    reset_model();

    first_frame = 1'b1;
    frame(16, 8, 1'b0);
    first_frame = 1'b0;
    frame(16, 480, 1'b0);
    frame(16, 16, 1'b1);
    frame(16, 16, 1'b0);
    for (int i = 0; i < 18; i++) begin
      cursor_en = (i != 14);
      frame(48, 24, 1'b0);
    end
    cursor_en = 1'b1;

    // Reset in the middle of a line, asynchronously to the clock
    for (int x = 0; x < 300; x++) step(x, 0, 1'b1, 1'b0, 1'b0);
    x_in = 10'd300; de_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pix_out", pix_out, 0);
    chk("async_rst_de_out", de_out, 0);
    chk("async_rst_hs_out", hs_out, 0);
    chk("async_rst_vs_out", vs_out, 0);
    x_in = '0; de_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    // frame_cnt restarts at 0, so the cursor must stay dark this frame
    frame(48, 24, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
